// File: rtl/fpga_top.sv
// fpga_top: UART front end with a power-up banner and a byte echo.
//
// After reset the transmitter sends "OK\r\n". After that, every correctly
// framed byte received on io_rx is queued in a small FIFO and sent back
// out on io_tx. The receiver runs while the banner is being sent, so bytes
// that arrive during the banner are echoed after it.
//
// Ports
//   clock  in   system clock, every flop on the rising edge
//   reset  in   synchronous, active-high reset
//   io_rx  in   UART serial in (asynchronous, idle high)
//   io_tx  out  UART serial out (8N1, LSB first, idle high), registered
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (at least 4)
//   FIFO_DEPTH    echo FIFO entries (power of two, at least 2)
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a synchronised 0
//   RX_START | half a bit into the start bit, then confirm it is still 0
//   RX_DATA  | sample d0..d7 once per bit period, LSB first
//   RX_STOP  | sample the stop bit; on a 0, wait here for the line to go high
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | nothing to send, line held high
//   TX_START | start bit (0) for one bit period
//   TX_DATA  | d0..d7, one bit period each
//   TX_STOP  | stop bit (1); a pending byte loads on its last cycle

module fpga_top #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic io_rx,
  output logic io_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // ------------------------------------------------------------------
  // RX synchroniser: flops reset to the idle level so a reset does not
  // look like a start bit.
  // ------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], io_rx};
    end
  end

  assign rx_s = sync_q[1];

  // ------------------------------------------------------------------
  // UART receiver
  // ------------------------------------------------------------------
  rx_state_e     rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_ferr_q;
  logic          rx_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ferr_q  <= 1'b0;
    end else begin
      unique case (rx_state_q)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= HALF_LAST;
            rx_bit_q   <= '0;
            rx_ferr_q  <= 1'b0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            if (!rx_s) begin
              rx_state_q <= RX_DATA;
              rx_cnt_q   <= BIT_LAST;
            end else begin
              rx_state_q <= RX_IDLE;   // glitch, not a real start bit
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            rx_cnt_q   <= BIT_LAST;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_ferr_q) begin
            // Framing error: a low line must not be mistaken for a new
            // start bit, so hold here until it returns high.
            if (rx_s) begin
              rx_state_q <= RX_IDLE;
              rx_ferr_q  <= 1'b0;
            end
          end else if (rx_cnt_q == '0) begin
            if (rx_s) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_ferr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CW'(1);
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // The byte is valid in the cycle the stop bit is sampled high; it is
  // pushed into the FIFO on that same edge.
  assign rx_valid = (rx_state_q == RX_STOP) && !rx_ferr_q &&
                    (rx_cnt_q == '0) && rx_s;

  // ------------------------------------------------------------------
  // Echo FIFO
  // ------------------------------------------------------------------
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = fifo_mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the head slot, so a push into a full
  // FIFO is still accepted then; otherwise a push while full is dropped.
  assign fifo_push = rx_valid && (!fifo_full || fifo_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_push) begin
      fifo_mem_q[wr_ptr_q[AW-1:0]] <= rx_shift_q;
    end
  end

  // ------------------------------------------------------------------
  // Banner ROM and TX source selection
  // ------------------------------------------------------------------
  logic [2:0] ban_idx_q;
  logic       ban_active;
  logic [7:0] ban_byte;
  logic       tx_avail;
  logic       tx_load;
  logic [7:0] tx_byte;

  assign ban_active = !ban_idx_q[2];

  always_comb begin
    unique case (ban_idx_q[1:0])
      2'd0:    ban_byte = 8'h4F;   // 'O'
      2'd1:    ban_byte = 8'h4B;   // 'K'
      2'd2:    ban_byte = 8'h0D;   // CR
      default: ban_byte = 8'h0A;   // LF
    endcase
  end

  // ------------------------------------------------------------------
  // UART transmitter
  // ------------------------------------------------------------------
  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          io_tx_q;

  assign tx_avail = ban_active || !fifo_empty;
  assign tx_byte  = ban_active ? ban_byte : fifo_head;

  // Loading on the last stop-bit cycle keeps queued frames back-to-back.
  assign tx_load  = tx_avail &&
                    ((tx_state_q == TX_IDLE) ||
                     ((tx_state_q == TX_STOP) && (tx_cnt_q == '0)));
  assign fifo_pop = tx_load && !ban_active;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      io_tx_q    <= 1'b1;
      ban_idx_q  <= '0;
    end else begin
      // io_tx follows the state one cycle late, so every bit (start
      // included) is on the pin for exactly CLKS_PER_BIT cycles.
      unique case (tx_state_q)
        TX_START: io_tx_q <= 1'b0;
        TX_DATA:  io_tx_q <= tx_shift_q[0];
        default:  io_tx_q <= 1'b1;
      endcase

      if (tx_load) begin
        tx_state_q <= TX_START;
        tx_cnt_q   <= BIT_LAST;
        tx_bit_q   <= '0;
        tx_shift_q <= tx_byte;
        if (ban_active) begin
          ban_idx_q <= ban_idx_q + 3'd1;
        end
      end else begin
        unique case (tx_state_q)
          TX_IDLE: begin
          end
          TX_START: begin
            if (tx_cnt_q == '0) begin
              tx_state_q <= TX_DATA;
              tx_cnt_q   <= BIT_LAST;
            end else begin
              tx_cnt_q <= tx_cnt_q - CW'(1);
            end
          end
          TX_DATA: begin
            if (tx_cnt_q == '0) begin
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_cnt_q   <= BIT_LAST;
              if (tx_bit_q == 3'd7) begin
                tx_state_q <= TX_STOP;
              end else begin
                tx_bit_q <= tx_bit_q + 3'd1;
              end
            end else begin
              tx_cnt_q <= tx_cnt_q - CW'(1);
            end
          end
          TX_STOP: begin
            if (tx_cnt_q == '0) begin
              tx_state_q <= TX_IDLE;
            end else begin
              tx_cnt_q <= tx_cnt_q - CW'(1);
            end
          end
          default: tx_state_q <= TX_IDLE;
        endcase
      end
    end
  end

  assign io_tx = io_tx_q;

endmodule

// File: tb/tb_fpga_top.sv
module tb_fpga_top;

  localparam int CPB   = 4;
  localparam int DEPTH = 2;
  localparam int FRAME = 10 * CPB;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic io_rx = 1'b1;
  logic io_tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rel    = 0;

  // Decoded io_tx frames: {stop bit, data byte} and the cycle of the start bit.
  logic [8:0] mon_q[$];
  int         mon_t[$];

  string banner = "OK\r\n";

  fpga_top #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .io_rx (io_rx),
    .io_tx (io_tx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Line monitor: an independent UART receiver sampling mid-bit on negedges.
  initial begin : monitor
    logic [7:0] d;
    logic       stp;
    int         t0;
    forever begin
      @(negedge clock);
      if (io_tx === 1'b0) begin
        t0 = cyc;
        repeat (CPB / 2 - 1) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          d[i] = io_tx;
        end
        repeat (CPB) @(negedge clock);
        stp = io_tx;
        mon_q.push_back({stp, d});
        mon_t.push_back(t0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [8:0] mon_at(input int i);
    if (i < mon_q.size()) return mon_q[i];
    return 9'h000;
  endfunction

  function automatic int mon_t_at(input int i);
    if (i < mon_t.size()) return mon_t[i];
    return -1000;
  endfunction

  task automatic flush_mon();
    mon_q.delete();
    mon_t.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    io_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      io_rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    io_rx = stop_v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    int k = 0;
    while (mon_q.size() < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    ok = (mon_q.size() >= n);
  endtask

  task automatic apply_reset(input int hold);
    reset = 1'b1;
    repeat (hold) @(negedge clock);
    flush_mon();
    reset = 1'b0;
    rel = cyc;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    checks++;
    if (io_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx_high: io_tx=%b required 1", io_tx);
    end
    flush_mon();
    reset = 1'b0;
    rel = cyc;
    @(negedge clock);
    checks++;
    if (io_tx !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_idle: io_tx=%b required 1", io_tx);
    end
    @(negedge clock);
    checks++;
    if (io_tx !== 1'b0) begin
      errors++;
      $display("FAIL second_edge_start: io_tx=%b required 0", io_tx);
    end
  endtask

  task automatic test_banner();
    bit ok;
    wait_frames(4, 6 * FRAME, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL banner_timeout: frames=%0d required 4", mon_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mon_at(i) !== {1'b1, banner[i]}) begin
        errors++;
        $display("FAIL banner_byte%0d: got %h required %h", i, mon_at(i), {1'b1, banner[i]});
      end
    end
    checks++;
    if (mon_t_at(0) - rel !== 2) begin
      errors++;
      $display("FAIL banner_start_latency: got %0d required 2", mon_t_at(0) - rel);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (mon_t_at(i) - mon_t_at(i - 1) !== FRAME) begin
        errors++;
        $display("FAIL banner_spacing%0d: got %0d required %0d", i, mon_t_at(i) - mon_t_at(i - 1), FRAME);
      end
    end
    repeat (2 * FRAME) @(negedge clock);
    checks++;
    if (mon_q.size() !== 4 || io_tx !== 1'b1) begin
      errors++;
      $display("FAIL banner_then_idle: frames=%0d io_tx=%b required 4 and 1", mon_q.size(), io_tx);
    end
  endtask

  task automatic test_echo();
    bit         ok;
    logic [7:0] b;
    int         s;
    int         lat;
    for (int n = 0; n < 4; n++) begin
      flush_mon();
      b = (n == 0) ? 8'h55 : 8'($urandom);
      s = cyc;
      send_byte(b, 1'b1);
      wait_frames(1, 2 * FRAME, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL echo%0d_timeout: no frame, required %h", n, b);
      end
      checks++;
      if (mon_at(0) !== {1'b1, b}) begin
        errors++;
        $display("FAIL echo%0d_data: got %h required %h", n, mon_at(0), {1'b1, b});
      end
      lat = mon_t_at(0) - s;
      checks++;
      if (lat < 9 * CPB || lat > FRAME + 4) begin
        errors++;
        $display("FAIL echo%0d_latency: got %0d required %0d..%0d", n, lat, 9 * CPB, FRAME + 4);
      end
      repeat (FRAME) @(negedge clock);
    end
  endtask

  task automatic test_frame_err();
    bit         ok;
    logic [7:0] b;
    flush_mon();
    send_byte(8'hA5, 1'b0);
    io_rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    b = 8'($urandom);
    send_byte(b, 1'b1);
    wait_frames(1, 3 * FRAME, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ferr_timeout: no frame, required %h", b);
    end
    checks++;
    if (mon_at(0) !== {1'b1, b}) begin
      errors++;
      $display("FAIL ferr_good_byte: got %h required %h", mon_at(0), {1'b1, b});
    end
    repeat (2 * FRAME) @(negedge clock);
    checks++;
    if (mon_q.size() !== 1) begin
      errors++;
      $display("FAIL ferr_count: frames=%0d required 1", mon_q.size());
    end
  endtask

  task automatic test_glitch();
    bit         ok;
    logic [7:0] b;
    flush_mon();
    io_rx = 1'b0;
    @(negedge clock);
    io_rx = 1'b1;
    repeat (3 * FRAME) @(negedge clock);
    checks++;
    if (mon_q.size() !== 0) begin
      errors++;
      $display("FAIL glitch_echo: frames=%0d required 0", mon_q.size());
    end
    io_rx = 1'b0;
    repeat (5 * FRAME) @(negedge clock);
    io_rx = 1'b1;
    repeat (3 * FRAME) @(negedge clock);
    checks++;
    if (mon_q.size() !== 0) begin
      errors++;
      $display("FAIL stuck_low_echo: frames=%0d required 0", mon_q.size());
    end
    b = 8'($urandom);
    send_byte(b, 1'b1);
    wait_frames(1, 2 * FRAME, ok);
    checks++;
    if (!ok || mon_at(0) !== {1'b1, b}) begin
      errors++;
      $display("FAIL stuck_low_recover: got %h required %h", mon_at(0), {1'b1, b});
    end
    repeat (FRAME) @(negedge clock);
  endtask

  task automatic test_back_to_back();
    bit         ok;
    logic [8:0] exp[6];
    apply_reset(3);
    repeat (10) @(negedge clock);
    send_byte(8'h31, 1'b1);
    send_byte(8'h32, 1'b1);
    io_rx = 1'b1;
    for (int i = 0; i < 4; i++) exp[i] = {1'b1, banner[i]};
    exp[4] = 9'h131;
    exp[5] = 9'h132;
    wait_frames(6, 10 * FRAME, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout: frames=%0d required 6", mon_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (mon_at(i) !== exp[i]) begin
        errors++;
        $display("FAIL b2b_byte%0d: got %h required %h", i, mon_at(i), exp[i]);
      end
    end
    for (int i = 1; i < 6; i++) begin
      checks++;
      if (mon_t_at(i) - mon_t_at(i - 1) !== FRAME) begin
        errors++;
        $display("FAIL b2b_spacing%0d: got %0d required %0d", i, mon_t_at(i) - mon_t_at(i - 1), FRAME);
      end
    end
    repeat (FRAME) @(negedge clock);
  endtask

  task automatic test_overflow();
    bit         ok;
    logic [7:0] bytes[6];
    int         push_t[6];
    logic [7:0] q[$];
    logic [7:0] exp[$];
    int         s0;
    int         busy_until;
    apply_reset(3);
    repeat (20) @(negedge clock);
    s0 = cyc;
    for (int k = 0; k < 6; k++) begin
      bytes[k]  = 8'($urandom);
      push_t[k] = s0 + FRAME * (k + 1);
    end
    // Model: the transmitter is busy with the banner for 4 frames, then takes
    // one queued byte per frame time; a byte arriving to a full queue is lost.
    busy_until = rel + 4 * FRAME;
    for (int t = rel; t < rel + 20 * FRAME; t++) begin
      if (t >= busy_until && q.size() > 0) begin
        exp.push_back(q.pop_front());
        busy_until = t + FRAME;
      end
      for (int k = 0; k < 6; k++) begin
        if (t == push_t[k] && q.size() < DEPTH) q.push_back(bytes[k]);
      end
    end
    for (int k = 0; k < 6; k++) send_byte(bytes[k], 1'b1);
    io_rx = 1'b1;
    wait_frames(4 + exp.size(), 20 * FRAME, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ovf_timeout: frames=%0d required %0d", mon_q.size(), 4 + exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (mon_at(4 + i) !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL ovf_echo%0d: got %h required %h", i, mon_at(4 + i), {1'b1, exp[i]});
      end
    end
    repeat (3 * FRAME) @(negedge clock);
    checks++;
    if (mon_q.size() !== 4 + exp.size()) begin
      errors++;
      $display("FAIL ovf_count: frames=%0d required %0d", mon_q.size(), 4 + exp.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset(3);
    repeat (43) @(negedge clock);
    checks++;
    if (io_tx !== 1'b0) begin
      errors++;
      $display("FAIL mid_start_bit: io_tx=%b required 0", io_tx);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (io_tx !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_tx: io_tx=%b required 1", io_tx);
    end
    repeat (50) @(negedge clock);
    flush_mon();
    reset = 1'b0;
    rel = cyc;
    wait_frames(4, 6 * FRAME, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_restart_timeout: frames=%0d required 4", mon_q.size());
    end
    checks++;
    if (mon_t_at(0) - rel !== 2) begin
      errors++;
      $display("FAIL mid_restart_latency: got %0d required 2", mon_t_at(0) - rel);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mon_at(i) !== {1'b1, banner[i]}) begin
        errors++;
        $display("FAIL mid_restart_byte%0d: got %h required %h", i, mon_at(i), {1'b1, banner[i]});
      end
    end
  endtask

  initial begin : main
    test_reset();
    test_banner();
    test_echo();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
